// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux, with a bounded hold time per owner.
// Optional build macro MUX_ARB_PRIO0_EN makes requester 0 urgent (wins in idle, preempts other owners).
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_GRANT   = 1'b1;
    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    // First set request strictly after 'last', wrapping 3->0; 'last' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    logic [0:0]       state_r,  state_s;
    logic [3:0]       grant_r,  grant_s;
    logic [1:0]       sel_r,    sel_s;
    logic             busy_r,   busy_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;
    logic [1:0]       last_r,   last_s;
    logic [3:0]       others_s;
    logic [1:0]       win_s;

    assign others_s = req & ~onehot(sel_r);

    // Next-state decision: idle arbitration, release handover, hold-limit preemption.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        sel_s   = sel_r;
        busy_s  = busy_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        win_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
`ifdef MUX_ARB_PRIO0_EN
                    win_s = req[0] ? 2'd0 : rr_pick(last_r, req);
`else
                    win_s = rr_pick(last_r, req);
`endif
                    grant_s = onehot(win_s);
                    sel_s   = win_s;
                    busy_s  = 1'b1;
                    cnt_s   = CNT_ONE;
                    state_s = ST_GRANT;
                end else begin
                    grant_s = 4'b0000;
                    busy_s  = 1'b0;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_GRANT: begin
`ifdef MUX_ARB_PRIO0_EN
                // Urgent requester 0 takes over from any other owner, even on a same-cycle release.
                if ((sel_r != 2'd0) && req[0]) begin
                    last_s  = sel_r;
                    grant_s = 4'b0001;
                    sel_s   = 2'd0;
                    cnt_s   = CNT_ONE;
                end else
`endif
                if (!req[sel_r]) begin
                    last_s = sel_r;
                    if (req != 4'b0000) begin
                        win_s   = rr_pick(sel_r, req);
                        grant_s = onehot(win_s);
                        sel_s   = win_s;
                        cnt_s   = CNT_ONE;
                    end else begin
                        grant_s = 4'b0000;
                        busy_s  = 1'b0;
                        cnt_s   = CNT_ZERO;
                        state_s = ST_IDLE;
                    end
                end else if ((cnt_r == MAX_HOLD_C) && (others_s != 4'b0000)) begin
                    // Search only the others so the timed-out owner can never re-win.
                    last_s  = sel_r;
                    win_s   = rr_pick(sel_r, others_s);
                    grant_s = onehot(win_s);
                    sel_s   = win_s;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s = (cnt_r == MAX_HOLD_C) ? cnt_r : cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                busy_s  = 1'b0;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Arbitration state and registered outputs; last owner resets to 3 so requester 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= 4'b0000;
            sel_r   <= 2'd0;
            busy_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
            last_r  <= 2'd3;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
        end
    end

    assign grant    = grant_r;
    assign sel      = sel_r;
    assign busy     = busy_r;
    assign hold_cnt = cnt_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: expected {grant,sel,busy,hold_cnt} queued per cycle, compared per scenario.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] hold_cnt;

    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    int          n_checks;
    int          n_fails;

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] mk(input logic [3:0] g, input logic [1:0] s,
                                       input logic b, input logic [3:0] c);
        return {g, s, b, c};
    endfunction

    // Drive req, let one rising edge sample it, record what came out and what should have.
    task automatic cyc(input logic [3:0] r, input logic [10:0] e);
        req = r;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        obs_q.push_back({grant, sel, busy, hold_cnt});
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e, o;
        req   = 4'b0000;
        rst_n = 1'b0;
        #2;
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 4'd0));
        obs_q.push_back({grant, sel, busy, hold_cnt});
        rst_n = 1'b1;
        cyc(4'b0000, mk(4'b0000, 2'd0, 1'b0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL reset: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic test_single();
        logic [10:0] e, o;
        do_reset();
        cyc(4'b0001, mk(4'b0001, 2'd0, 1'b1, 4'd1));
        cyc(4'b0000, mk(4'b0000, 2'd0, 1'b0, 4'd0));
        cyc(4'b0000, mk(4'b0000, 2'd0, 1'b0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL single: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic test_rotate();
        logic [10:0] e, o;
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 1; k <= 8; k++) begin
                    cyc(4'b1111, mk(4'b0001 << i, 2'(i), 1'b1, 4'(k)));
                end
            end
        end
        cyc(4'b1111, mk(4'b0001, 2'd0, 1'b1, 4'd1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL rotate: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic test_release();
        logic [10:0] e, o;
        do_reset();
        cyc(4'b0101, mk(4'b0001, 2'd0, 1'b1, 4'd1));
        cyc(4'b0101, mk(4'b0001, 2'd0, 1'b1, 4'd2));
        cyc(4'b0101, mk(4'b0001, 2'd0, 1'b1, 4'd3));
        cyc(4'b0100, mk(4'b0100, 2'd2, 1'b1, 4'd1));
        cyc(4'b0100, mk(4'b0100, 2'd2, 1'b1, 4'd2));
        cyc(4'b0000, mk(4'b0000, 2'd2, 1'b0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL release: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic test_sole_saturate();
        logic [10:0] e, o;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc(4'b0010, mk(4'b0010, 2'd1, 1'b1, (k > 8) ? 4'd8 : 4'(k)));
        end
        cyc(4'b1010, mk(4'b1000, 2'd3, 1'b1, 4'd1));
        cyc(4'b0000, mk(4'b0000, 2'd3, 1'b0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL sole_saturate: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] e, o;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cyc(4'b0100, mk(4'b0100, 2'd2, 1'b1, 4'(k)));
        end
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 4'd0));
        obs_q.push_back({grant, sel, busy, hold_cnt});
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        cyc(4'b1001, mk(4'b0001, 2'd0, 1'b1, 4'd1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL async_reset: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic test_prio0();
        logic [10:0] e, o;
        do_reset();
        cyc(4'b0100, mk(4'b0100, 2'd2, 1'b1, 4'd1));
        cyc(4'b0100, mk(4'b0100, 2'd2, 1'b1, 4'd2));
`ifdef MUX_ARB_PRIO0_EN
        cyc(4'b1101, mk(4'b0001, 2'd0, 1'b1, 4'd1));
        cyc(4'b1101, mk(4'b0001, 2'd0, 1'b1, 4'd2));
`else
        for (int k = 3; k <= 8; k++) begin
            cyc(4'b1101, mk(4'b0100, 2'd2, 1'b1, 4'(k)));
        end
        cyc(4'b1101, mk(4'b1000, 2'd3, 1'b1, 4'd1));
        cyc(4'b0101, mk(4'b0001, 2'd0, 1'b1, 4'd1));
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL prio0: got g=%b s=%0d b=%b c=%0d expected g=%b s=%0d b=%b c=%0d",
                         o[10:7], o[6:5], o[4], o[3:0], e[10:7], e[6:5], e[4], e[3:0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        req      = 4'b0000;
        rst_n    = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_release();
        test_sole_saturate();
        test_async_reset();
        test_prio0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
